// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running fetch/flush event counters; both wrap at 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_inc_i,
  input  logic        flush_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_inc_i};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_inc_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request FSM, one-entry skid and IF/ID register.
// Performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [31:0]     br_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] cur_pc,
  output logic            ifid_valid,
  output logic [PC_W-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt,
  output logic [1:0]      dbg_state
);

  // Handshake: imem_req rises with imem_addr stable and both hold until the
  // cycle imem_ack is sampled high; rdata is consumed in that same cycle.

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] drop_addr_q, drop_addr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [31:0]     skid_q, skid_d;
  logic            fetch_inc, flush_inc;
  logic [PC_W-1:0] pc_next;

  assign pc_next = pc_q + PC_W'(PC_INC);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    skid_d       = skid_q;
    fetch_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (pc_sel) begin
          // An unacked request cannot be withdrawn; drain it in DROP.
          state_d     = imem_ack ? ST_REQ : ST_DROP;
          drop_addr_d = pc_q;
        end else if (imem_ack) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            pc_d         = pc_next;
            fetch_inc    = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (pc_sel) begin
          state_d = ST_REQ;
        end else if (!stall) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = pc_q;
          ifid_instr_d = skid_q;
          pc_d         = pc_next;
          fetch_inc    = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_DROP: if (imem_ack) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase
    // Redirect overrides everything, including stall.
    if (pc_sel) begin
      pc_d         = br_pc[PC_W-1:0];
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      flush_inc    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      skid_q       <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      skid_q       <= skid_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr  = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  assign cur_pc     = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign dbg_state  = state_q;

  logic unused_br_pc;
  assign unused_br_pc = ^br_pc[31:PC_W];

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk         (clk),
    .reset       (reset),
    .fetch_inc_i (fetch_inc),
    .flush_inc_i (flush_inc),
    .fetch_cnt_o (fetch_cnt),
    .flush_cnt_o (flush_cnt)
  );
`else
  logic unused_inc;
  assign unused_inc = fetch_inc ^ flush_inc;
  assign fetch_cnt  = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming fetch, stall/skid, redirects, wrap, reset mid-request.
module tb_fetch_stage;

  localparam int PC_W = 9;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_DROP = 2'd3;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic            pc_sel = 1'b0;
  logic [31:0]     br_pc = '0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic [PC_W-1:0] cur_pc;
  logic            ifid_valid;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic [31:0]     fetch_cnt, flush_cnt;
  logic [1:0]      dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .br_pc(br_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .cur_pc(cur_pc), .ifid_valid(ifid_valid),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    chk({tag, ".pc"}, 32'(ifid_pc), pc);
    chk({tag, ".instr"}, ifid_instr, ins);
  endtask

  task automatic chk_req(input string tag, input logic [1:0] st, input logic rq, input logic [31:0] addr);
    chk({tag, ".state"}, {30'd0, dbg_state}, {30'd0, st});
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, rq});
    chk({tag, ".addr"}, 32'(imem_addr), addr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_req(tag, S_IDLE, 1'b0, 32'h0);
    chk({tag, ".cur_pc"}, 32'(cur_pc), 32'h0);
    chk_if(tag, 1'b0, 32'h0, NOP);
    chk({tag, ".fetch_cnt"}, fetch_cnt, 32'h0);
    chk({tag, ".flush_cnt"}, flush_cnt, 32'h0);
  endtask

  initial begin
    // Reset
    step(); step();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Streaming fetch, ack every cycle
    step();
    chk_req("first_req", S_REQ, 1'b1, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h11;
    step();
    chk_if("fetch0", 1'b1, 32'h0, 32'h11);
    chk_req("fetch0", S_REQ, 1'b1, 32'h4);
    imem_rdata = 32'h22;
    step();
    chk_if("fetch4", 1'b1, 32'h4, 32'h22);
    chk_req("fetch4", S_REQ, 1'b1, 32'h8);

    // Stall coincident with ack of PC 8, held three cycles
    imem_rdata = 32'h33; stall = 1'b1;
    step();
    imem_ack = 1'b0; imem_rdata = 32'hBAD0BAD0;
    chk_req("hold1", S_HOLD, 1'b0, 32'h8);
    chk_if("hold1", 1'b1, 32'h4, 32'h22);
    step();
    chk_req("hold2", S_HOLD, 1'b0, 32'h8);
    step();
    chk_if("hold3", 1'b1, 32'h4, 32'h22);
    stall = 1'b0;
    step();
    chk_if("release", 1'b1, 32'h8, 32'h33);
    chk_req("release", S_REQ, 1'b1, 32'hC);

    // Fetch PC 0xC, then redirect while PC 0x10 waits for ack
    imem_ack = 1'b1; imem_rdata = 32'h44;
    step();
    chk_if("fetchC", 1'b1, 32'hC, 32'h44);
    imem_ack = 1'b0; pc_sel = 1'b1; br_pc = 32'h40;
    step();
    pc_sel = 1'b0;
    chk_req("drop", S_DROP, 1'b1, 32'h10);
    chk("drop.cur_pc", 32'(cur_pc), 32'h40);
    chk_if("drop", 1'b0, 32'hC, NOP);
    chk("drop.flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    step();
    chk_req("drop_wait", S_DROP, 1'b1, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD;
    step();
    chk_req("after_drop", S_REQ, 1'b1, 32'h40);
    chk("after_drop.valid", {31'd0, ifid_valid}, 32'd0);

    // Fetch 0x40, then redirect and stall in the same cycle
    imem_rdata = 32'h55;
    step();
    chk_if("fetch40", 1'b1, 32'h40, 32'h55);
    imem_ack = 1'b0; pc_sel = 1'b1; stall = 1'b1; br_pc = 32'h80;
    step();
    pc_sel = 1'b0; stall = 1'b0;
    chk("sel_stall.cur_pc", 32'(cur_pc), 32'h80);
    chk_if("sel_stall", 1'b0, 32'h40, NOP);
    chk_req("sel_stall", S_DROP, 1'b1, 32'h44);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD;
    step();
    chk_req("drop2_done", S_REQ, 1'b1, 32'h80);

    // Redirect with ack in REQ: data discarded, then fetch at 0x1FC wraps PC
    pc_sel = 1'b1; br_pc = 32'h1FC;
    step();
    pc_sel = 1'b0;
    chk_req("sel_ack", S_REQ, 1'b1, 32'h1FC);
    chk("sel_ack.valid", {31'd0, ifid_valid}, 32'd0);
    imem_rdata = 32'h66;
    step();
    chk_if("fetch1FC", 1'b1, 32'h1FC, 32'h66);
    chk("wrap.cur_pc", 32'(cur_pc), 32'h0);
    chk("perf.fetch_cnt", fetch_cnt, PERF ? 32'd6 : 32'd0);
    chk("perf.flush_cnt", flush_cnt, PERF ? 32'd3 : 32'd0);

    // Reset while a request is outstanding, then a late ack
    imem_ack = 1'b0;
    chk_req("pre_reset", S_REQ, 1'b1, 32'h0);
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    step();
    imem_ack = 1'b1; imem_rdata = 32'h77;
    reset = 1'b0;
    step();
    imem_ack = 1'b0;
    chk_req("late_ack", S_REQ, 1'b1, 32'h0);
    chk_if("late_ack", 1'b0, 32'h0, NOP);
    chk("late_ack.cur_pc", 32'(cur_pc), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_W, default 9, width of program counter and instruction-memory byte address.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  hazard stall from decode; IF/ID register and PC hold while high.
REQ-006 pc_sel  in  1  redirect request from branch resolution; 1 = take br_pc.
REQ-007 br_pc  in  32  redirect target; only bits [PC_W-1:0] used.
REQ-008 imem_req  out  1  instruction-memory request, held until imem_ack.
REQ-009 imem_addr  out  PC_W  byte address of outstanding request.
REQ-010 imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in same cycle.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 cur_pc  out  PC_W  current architectural PC.
REQ-013 ifid_valid  out  1  IF/ID register holds a live instruction.
REQ-014 ifid_pc  out  PC_W  PC of instruction in IF/ID.
REQ-015 ifid_instr  out  32  instruction in IF/ID; NOP when ifid_valid=0.
REQ-016 fetch_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD, DROP.
REQ-018 IDLE: one cycle after reset, imem_req=0, then go to REQ.
REQ-019 REQ: imem_req=1, imem_addr=cur_pc; on imem_ack with stall=0 and pc_sel=0: IF/ID <= {1, cur_pc, imem_rdata}, cur_pc <= cur_pc+4, stay REQ.
REQ-020 REQ with imem_ack and stall=1: capture instruction into a one-entry skid buffer, go HOLD; cur_pc unchanged.
REQ-021 HOLD: imem_req=0; when stall falls, skid entry moves to IF/ID, cur_pc <= cur_pc+4, go REQ.
REQ-022 pc_sel=1 in any state SHALL: cur_pc <= br_pc[PC_W-1:0], ifid_valid <= 0, ifid_instr <= 32'h00000013, skid entry discarded, flush_cnt incremented.
REQ-023 pc_sel=1 in REQ without imem_ack SHALL go DROP; pc_sel=1 in REQ with imem_ack discards rdata and goes REQ at new PC.
REQ-024 DROP: imem_req=1 with the old imem_addr held until imem_ack; returned data discarded; then REQ at redirected PC.
REQ-025 pc_sel has priority over stall; stall never blocks a redirect.
REQ-026 While stall=1 and pc_sel=0, ifid_valid/pc/instr SHALL hold.
REQ-027 cur_pc+4 SHALL wrap modulo 2^PC_W.
REQ-028 imem_req SHALL never deassert before imem_ack once asserted (no withdrawn requests).
REQ-029 Fetch latency: instruction visible in IF/ID the cycle after imem_ack.

Reset
REQ-030 Reset SHALL force: state=IDLE, cur_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=32'h00000013, skid empty, counters 0.
REQ-031 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset in IDLE SHALL be ignored.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: fetch_cnt increments on each instruction entering IF/ID, flush_cnt per REQ-022; both wrap at 2^32.
REQ-033 Macro undefined: fetch_cnt and flush_cnt ports present, tied to 0, no counter flops.

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enum, NOP_INSTR=32'h00000013 and PC_INC=4.
REQ-035 Counters SHALL live in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-036 Reset then ack every cycle, rdata 0x11,0x22,0x33 -> ifid_pc 0,4,8 with matching instr, ifid_valid=1 from cycle 3.
REQ-037 stall=1 for 3 cycles coincident with ack of PC 8 -> HOLD, imem_req=0, IF/ID holds PC 4; after release IF/ID=PC 8, next imem_addr=12.
REQ-038 pc_sel=1, br_pc=0x40 while REQ waiting on PC 0x10 -> DROP; ack of 0x10 discarded; next imem_addr=0x40, ifid_valid=0 meanwhile, flush_cnt=1.
REQ-039 pc_sel=1 and stall=1 same cycle, br_pc=0x80 -> cur_pc=0x80, IF/ID flushed to NOP.
REQ-040 cur_pc=0x1FC (PC_W=9) fetched -> cur_pc wraps to 0x000.
REQ-041 reset asserted while imem_req=1 -> all outputs at REQ-030 values within the same cycle; late ack ignored.
